// File: rtl/score_view_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : score_view_pkg
//  Description : Shared configuration, note-store entry layout and geometry
//                helpers for the scrolling score renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
package score_view_pkg;

    // Default screen / score geometry
    localparam int c_SCREEN_WIDTH       = 800;
    localparam int c_SCREEN_HEIGHT      = 480;
    localparam int c_SCREEN_WIDTH_BITS  = 11;
    localparam int c_SCREEN_HEIGHT_BITS = 10;
    localparam int c_DISPLAYED_BEATS    = 6;
    localparam int c_SIMULTANEOUS_NOTES = 4;
    localparam int c_BEAT_DURATION      = 16;
    localparam int c_BEAT_BITS          = 7;
    localparam int c_NOTE_BITS          = 6;
    localparam int c_NOTES_POS_BITS     = 6;
    localparam int c_STEP_PX            = 8;
    localparam int c_MID_NOTE           = 34;

    // Two screens' worth of simultaneous notes so scrolled-out bars still fit
    localparam int c_CAP = 2 * c_DISPLAYED_BEATS * c_SIMULTANEOUS_NOTES;

    // Entry layout {valid, note, start, duration}, LSB first
    localparam int c_DUR_LSB   = 0;
    localparam int c_START_LSB = c_BEAT_BITS;
    localparam int c_NOTE_LSB  = 2 * c_BEAT_BITS;
    localparam int c_VALID_BIT = 2 * c_BEAT_BITS + c_NOTE_BITS;
    localparam int c_ENTRY_W   = c_VALID_BIT + 1;

    typedef struct packed {
        logic                   valid;
        logic [c_NOTE_BITS-1:0] note;
        logic [c_BEAT_BITS-1:0] start;
        logic [c_BEAT_BITS-1:0] duration;
    } entry_t;

    // Horizontal pixels per tick (floored)
    function automatic int tick_px(input int width, input int beats, input int beat_dur);
        return width / (beats * beat_dur);
    endfunction

    // Row of staff line k, k = -2..2 around the screen middle
    function automatic int staff_line_y(input int height, input int step, input int k);
        return height / 2 + k * 2 * step;
    endfunction

endpackage : score_view_pkg
`default_nettype wire

// File: rtl/score_view_note_store.sv
`default_nettype none
// ============================================================================
//  Module      : note_store
//  Description : Circular store of timestamped note events, write pointer,
//                tick counter and age-out of entries about to alias.
//  Revision    : 1.0 - initial release
// ============================================================================
import score_view_pkg::*;

module note_store #(
    parameter int CAP      = c_CAP,
    parameter int POS_BITS = c_NOTES_POS_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_play,
    input  logic                     i_new_note,
    input  logic [c_NOTE_BITS-1:0]   i_note,
    input  logic [c_BEAT_BITS-1:0]   i_duration,
    input  logic                     i_new_beat,
    output logic [c_BEAT_BITS-1:0]   o_cur,
    output logic [CAP*c_ENTRY_W-1:0] o_entries
);

    // Age one step short of wrapping back to zero
    localparam logic [c_BEAT_BITS-1:0] c_AGE_MAX   = '1;
    localparam logic [POS_BITS-1:0]    c_WPTR_LAST = POS_BITS'(CAP - 1);

    entry_t                 r_store [CAP];
    logic [c_BEAT_BITS-1:0] r_cur;
    logic [POS_BITS-1:0]    r_wptr;

    logic w_record;
    logic w_tick;

    // Zero-length notes never occupy a slot; nothing moves while paused
    assign w_record = i_play & i_new_note & (i_duration != '0);
    assign w_tick   = i_play & i_new_beat;

    // Store, pointer and tick counter; a write to a slot wins over its age-out
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cur  <= '0;
            r_wptr <= '0;
            for (int i = 0; i < CAP; i++) begin
                r_store[i] <= '0;
            end
        end else begin
            if (w_tick) begin
                for (int i = 0; i < CAP; i++) begin
                    if (r_store[i].valid && ((r_cur - r_store[i].start) == c_AGE_MAX)) begin
                        r_store[i].valid <= 1'b0;
                    end
                end
                r_cur <= r_cur + 1'b1;
            end
            if (w_record) begin
                r_store[r_wptr] <= '{valid: 1'b1, note: i_note, start: r_cur, duration: i_duration};
                r_wptr          <= (r_wptr == c_WPTR_LAST) ? '0 : r_wptr + 1'b1;
            end
        end
    end

    assign o_cur = r_cur;

    for (genvar i = 0; i < CAP; i++) begin : g_flat
        assign o_entries[i*c_ENTRY_W +: c_ENTRY_W] = r_store[i];
    end

endmodule : note_store
`default_nettype wire

// File: rtl/score_view.sv
`default_nettype none
// ============================================================================
//  Module      : score_view
//  Description : Scrolling score renderer. Answers combinationally whether a
//                queried pixel lies on a recorded note bar or the staff grid.
//  Revision    : 1.0 - initial release
// ============================================================================
import score_view_pkg::*;

module score_view #(
    parameter int SCREEN_WIDTH       = c_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT      = c_SCREEN_HEIGHT,
    parameter int SCREEN_WIDTH_BITS  = c_SCREEN_WIDTH_BITS,
    parameter int SCREEN_HEIGHT_BITS = c_SCREEN_HEIGHT_BITS,
    parameter int DISPLAYED_BEATS    = c_DISPLAYED_BEATS,
    parameter int SIMULTANEOUS_NOTES = c_SIMULTANEOUS_NOTES,
    parameter int BEAT_DURATION      = c_BEAT_DURATION,
    parameter int BEAT_BITS          = c_BEAT_BITS,
    parameter int NOTE_BITS          = c_NOTE_BITS,
    parameter int NOTES_POS_BITS     = c_NOTES_POS_BITS,
    parameter int STEP_PX            = c_STEP_PX,
    parameter int MID_NOTE           = c_MID_NOTE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          play,
    input  logic                          new_note,
    input  logic [NOTE_BITS-1:0]          note,
    input  logic [BEAT_BITS-1:0]          duration,
    input  logic                          new_beat,
    input  logic [SCREEN_WIDTH_BITS-1:0]  x,
    input  logic [SCREEN_HEIGHT_BITS-1:0] y,
    output logic                          on_notes,
    output logic                          on_staff,
    output logic                          on
);

    localparam int c_NUM_ENTRIES = 2 * DISPLAYED_BEATS * SIMULTANEOUS_NOTES;
    localparam int c_TICK_PX     = tick_px(SCREEN_WIDTH, DISPLAYED_BEATS, BEAT_DURATION);
    // Signed width covering -216..1816 with margin
    localparam int c_CALC_W      = 16;

    localparam logic signed [c_CALC_W-1:0] c_WIDTH_S    = c_CALC_W'(SCREEN_WIDTH);
    localparam logic signed [c_CALC_W-1:0] c_TICK_S     = c_CALC_W'(c_TICK_PX);
    localparam logic signed [c_CALC_W-1:0] c_MID_Y_S    = c_CALC_W'(SCREEN_HEIGHT / 2);
    localparam logic signed [c_CALC_W-1:0] c_MID_NOTE_S = c_CALC_W'(MID_NOTE);
    localparam logic signed [c_CALC_W-1:0] c_STEP_S     = c_CALC_W'(STEP_PX);
    localparam logic signed [c_CALC_W-1:0] c_HALF_BAR_S = c_CALC_W'(3);
    localparam logic signed [c_CALC_W-1:0] c_BAND_TOP_S = c_CALC_W'(staff_line_y(SCREEN_HEIGHT, STEP_PX, -2));
    localparam logic signed [c_CALC_W-1:0] c_BAND_BOT_S = c_CALC_W'(staff_line_y(SCREEN_HEIGHT, STEP_PX, 2));

    logic [c_BEAT_BITS-1:0]                 w_cur;
    logic [c_NUM_ENTRIES*c_ENTRY_W-1:0]     w_entries;
    logic [c_NUM_ENTRIES-1:0]               w_hit;
    logic [4:0]                             w_hline;
    logic [DISPLAYED_BEATS-1:0]             w_vline;
    logic                                   w_band;
    logic signed [c_CALC_W-1:0]             w_x_s;
    logic signed [c_CALC_W-1:0]             w_y_s;

    note_store #(
        .CAP      (c_NUM_ENTRIES),
        .POS_BITS (NOTES_POS_BITS)
    ) u_note_store (
        .clk        (clk),
        .rst        (rst),
        .i_play     (play),
        .i_new_note (new_note),
        .i_note     (note),
        .i_duration (duration),
        .i_new_beat (new_beat),
        .o_cur      (w_cur),
        .o_entries  (w_entries)
    );

    assign w_x_s = $signed({{(c_CALC_W-SCREEN_WIDTH_BITS){1'b0}}, x});
    assign w_y_s = $signed({{(c_CALC_W-SCREEN_HEIGHT_BITS){1'b0}}, y});

    // One bar test per stored entry; playhead at the right edge
    for (genvar i = 0; i < c_NUM_ENTRIES; i++) begin : g_entry
        logic [c_ENTRY_W-1:0]       w_entry;
        logic                       w_valid;
        logic [c_NOTE_BITS-1:0]     w_note;
        logic [c_BEAT_BITS-1:0]     w_start;
        logic [c_BEAT_BITS-1:0]     w_dur;
        logic [c_BEAT_BITS-1:0]     w_age;
        logic signed [c_CALC_W-1:0] w_sx;
        logic signed [c_CALC_W-1:0] w_ex;
        logic signed [c_CALC_W-1:0] w_yc;

        assign w_entry = w_entries[i*c_ENTRY_W +: c_ENTRY_W];
        assign w_valid = w_entry[c_VALID_BIT];
        assign w_note  = w_entry[c_NOTE_LSB  +: c_NOTE_BITS];
        assign w_start = w_entry[c_START_LSB +: c_BEAT_BITS];
        assign w_dur   = w_entry[c_DUR_LSB   +: c_BEAT_BITS];

        // Modular age: the store retires entries before this can alias
        assign w_age = w_cur - w_start;
        assign w_sx  = c_WIDTH_S - $signed({{(c_CALC_W-c_BEAT_BITS){1'b0}}, w_age}) * c_TICK_S;
        assign w_ex  = w_sx + $signed({{(c_CALC_W-c_BEAT_BITS){1'b0}}, w_dur}) * c_TICK_S;
        assign w_yc  = c_MID_Y_S + (c_MID_NOTE_S - $signed({{(c_CALC_W-c_NOTE_BITS){1'b0}}, w_note})) * c_STEP_S;

        assign w_hit[i] = w_valid
                        && (w_x_s >= w_sx) && (w_x_s < w_ex)
                        && (w_y_s >= w_yc - c_HALF_BAR_S) && (w_y_s <= w_yc + c_HALF_BAR_S);
    end

    // Five horizontal staff lines spanning the full width
    for (genvar k = 0; k < 5; k++) begin : g_hline
        localparam logic signed [c_CALC_W-1:0] c_LINE_Y_S = c_CALC_W'(staff_line_y(SCREEN_HEIGHT, STEP_PX, k - 2));
        assign w_hline[k] = (w_y_s == c_LINE_Y_S);
    end

    // Beat grid lines, one per displayed beat counted back from the playhead
    for (genvar k = 1; k <= DISPLAYED_BEATS; k++) begin : g_vline
        localparam logic signed [c_CALC_W-1:0] c_GRID_X_S = c_CALC_W'(SCREEN_WIDTH - k * BEAT_DURATION * c_TICK_PX);
        assign w_vline[k-1] = (w_x_s == c_GRID_X_S);
    end

    assign w_band = (w_y_s >= c_BAND_TOP_S) && (w_y_s <= c_BAND_BOT_S);

    // Merge note and staff layers into the pixel answer
    always_comb begin
        on_notes = |w_hit;
        on_staff = (|w_hline) | ((|w_vline) & w_band);
        on       = on_notes | on_staff;
    end

endmodule : score_view
`default_nettype wire

// File: tb/tb_score_view.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_view
//  Description : Self-checking bench for score_view with a behavioural
//                reference model of the note store and pixel rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_view;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        play = 1'b0;
    logic        new_note = 1'b0;
    logic        new_beat = 1'b0;
    logic [5:0]  note = '0;
    logic [6:0]  duration = '0;
    logic [10:0] x = '0;
    logic [9:0]  y = '0;
    logic        on_notes;
    logic        on_staff;
    logic        on;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_valid [48];
    int m_note  [48];
    int m_start [48];
    int m_dur   [48];
    int m_cur  = 0;
    int m_wptr = 0;

    always #5 clk = ~clk;

    score_view dut (
        .clk      (clk),
        .rst      (rst),
        .play     (play),
        .new_note (new_note),
        .note     (note),
        .duration (duration),
        .new_beat (new_beat),
        .x        (x),
        .y        (y),
        .on_notes (on_notes),
        .on_staff (on_staff),
        .on       (on)
    );

    function automatic int m_age(input int i);
        return (m_cur - m_start[i] + 128) % 128;
    endfunction

    function automatic void model_edge(input bit r, input bit p, input bit nn,
                                       input int nt, input int d, input bit nb);
        if (!r) begin
            m_cur  = 0;
            m_wptr = 0;
            for (int i = 0; i < 48; i++) m_valid[i] = 1'b0;
            return;
        end
        if (!p) return;
        if (nb) begin
            for (int i = 0; i < 48; i++)
                if (m_valid[i] && m_age(i) == 127) m_valid[i] = 1'b0;
        end
        if (nn && d != 0) begin
            m_valid[m_wptr] = 1'b1;
            m_note[m_wptr]  = nt;
            m_start[m_wptr] = m_cur;
            m_dur[m_wptr]   = d;
            m_wptr = (m_wptr + 1) % 48;
        end
        if (nb) m_cur = (m_cur + 1) % 128;
    endfunction

    function automatic bit m_on_notes(input int px, input int py);
        for (int i = 0; i < 48; i++) begin
            if (m_valid[i]) begin
                int sx, ex, yc;
                sx = 800 - m_age(i) * 8;
                ex = sx + m_dur[i] * 8;
                yc = 240 + (34 - m_note[i]) * 8;
                if (px >= sx && px < ex && py >= yc - 3 && py <= yc + 3) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit m_on_staff(input int px, input int py);
        for (int k = -2; k <= 2; k++)
            if (py == 240 + k * 16) return 1'b1;
        if (py >= 208 && py <= 272)
            for (int k = 1; k <= 6; k++)
                if (px == 800 - k * 128) return 1'b1;
        return 1'b0;
    endfunction

    // Pixel picker biased towards the edges of live bars and grid lines
    function automatic void pick_pixel(output int px, output int py);
        int live [$];
        for (int i = 0; i < 48; i++) if (m_valid[i]) live.push_back(i);
        if (live.size() != 0 && $urandom_range(0, 3) != 0) begin
            int i, sx, ex, yc;
            i  = live[$urandom_range(0, live.size() - 1)];
            sx = 800 - m_age(i) * 8;
            ex = sx + m_dur[i] * 8;
            yc = 240 + (34 - m_note[i]) * 8;
            case ($urandom_range(0, 2))
                0: px = sx - 1 + int'($urandom_range(0, 2));
                1: px = ex - 1 + int'($urandom_range(0, 2));
                default: px = sx + int'($urandom_range(0, 1023)) % (ex - sx + 1);
            endcase
            py = yc - 4 + int'($urandom_range(0, 8));
        end else begin
            px = int'($urandom_range(0, 799));
            py = int'($urandom_range(200, 280));
        end
        if (px < 0) px = 0;
        if (px > 799) px = 799;
        if (py < 0) py = 0;
        if (py > 479) py = 479;
    endfunction

    task automatic cycle(input bit r, input bit p, input bit nn, input int nt,
                         input int d, input bit nb);
        @(negedge clk);
        rst = r; play = p; new_note = nn; note = nt[5:0]; duration = d[6:0]; new_beat = nb;
        @(posedge clk);
        model_edge(r, p, nn, nt, d, nb);
        @(negedge clk);
        rst = 1'b1; new_note = 1'b0; new_beat = 1'b0;
    endtask

    task automatic test_reset;
        // Reset wins over pulses arriving in the same cycle
        cycle(1'b0, 1'b1, 1'b1, 34, 16, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 34, 16, 1'b1);
        x = 400; y = 240; #1;
        n_checks++;
        if (on !== 1'b1 || on_staff !== 1'b1 || on_notes !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_400_240: on=%b on_staff=%b on_notes=%b required 1 1 0", on, on_staff, on_notes);
        end
        x = 400; y = 241; #1;
        n_checks++;
        if (on !== 1'b0) begin n_fail++; $display("FAIL reset_400_241: on=%b required 0", on); end
        x = 672; y = 230; #1;
        n_checks++;
        if (on_staff !== 1'b1) begin n_fail++; $display("FAIL reset_672_230: on_staff=%b required 1", on_staff); end
        x = 672; y = 300; #1;
        n_checks++;
        if (on !== 1'b0) begin n_fail++; $display("FAIL reset_672_300: on=%b required 0", on); end
        for (int j = 0; j < 30; j++) begin
            int px, py;
            px = int'($urandom_range(0, 799)); py = int'($urandom_range(0, 479));
            x = px[10:0]; y = py[9:0]; #1;
            n_checks++;
            if (on_notes !== 1'b0 || on !== on_staff || on_staff !== m_on_staff(px, py)) begin
                n_fail++;
                $display("FAIL reset_scan(%0d,%0d): on=%b on_staff=%b on_notes=%b required staff=%b notes=0",
                         px, py, on, on_staff, on_notes, m_on_staff(px, py));
            end
        end
    endtask

    task automatic test_single_bar;
        cycle(1'b1, 1'b1, 1'b1, 34, 16, 1'b0);
        repeat (16) cycle(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
        x = 700; y = 240; #1;
        n_checks++;
        if (on_notes !== 1'b1) begin n_fail++; $display("FAIL bar_700_240: on_notes=%b required 1", on_notes); end
        x = 671; y = 240; #1;
        n_checks++;
        if (on_notes !== 1'b0) begin n_fail++; $display("FAIL bar_671_240: on_notes=%b required 0", on_notes); end
        x = 700; y = 244; #1;
        n_checks++;
        if (on_notes !== 1'b0) begin n_fail++; $display("FAIL bar_700_244: on_notes=%b required 0", on_notes); end
        x = 700; y = 243; #1;
        n_checks++;
        if (on_notes !== 1'b1) begin n_fail++; $display("FAIL bar_700_243: on_notes=%b required 1", on_notes); end
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
        x = 656; y = 240; #1;
        n_checks++;
        if (on_notes !== 1'b1) begin n_fail++; $display("FAIL scroll_656_240: on_notes=%b required 1", on_notes); end
        x = 799; y = 240; #1;
        n_checks++;
        if (on_notes !== 1'b0) begin n_fail++; $display("FAIL scroll_799_240: on_notes=%b required 0", on_notes); end
    endtask

    task automatic test_freeze;
        int wp_before;
        wp_before = m_wptr;
        repeat (3) cycle(1'b1, 1'b0, 1'b1, 20, 50, 1'b1);
        x = 656; y = 240; #1;
        n_checks++;
        if (on_notes !== 1'b1) begin n_fail++; $display("FAIL freeze_656_240: on_notes=%b required 1", on_notes); end
        n_checks++;
        if (int'(dut.u_note_store.r_wptr) !== wp_before) begin
            n_fail++;
            $display("FAIL freeze_wptr: wptr=%0d required %0d", dut.u_note_store.r_wptr, wp_before);
        end
        for (int j = 0; j < 30; j++) begin
            int px, py;
            pick_pixel(px, py);
            x = px[10:0]; y = py[9:0]; #1;
            n_checks++;
            if (on_notes !== m_on_notes(px, py) || on !== (m_on_notes(px, py) | m_on_staff(px, py))) begin
                n_fail++;
                $display("FAIL freeze_scan(%0d,%0d): on=%b on_notes=%b required on_notes=%b", px, py, on, on_notes, m_on_notes(px, py));
            end
        end
        play = 1'b1;
    endtask

    task automatic test_wrap;
        cycle(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 49; i++) begin
            int d;
            if (i == 0) d = 127;
            else if (i % 16 == 0) d = 1;
            else d = int'($urandom_range(1, 127));
            cycle(1'b1, 1'b1, 1'b1, 27 + (i % 16), d, 1'b0);
        end
        n_checks++;
        if (int'(dut.u_note_store.r_wptr) !== 1) begin
            n_fail++;
            $display("FAIL wrap_wptr: wptr=%0d required 1", dut.u_note_store.r_wptr);
        end
        repeat (40) cycle(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
        x = 700; y = 296; #1;
        n_checks++;
        if (on_notes !== 1'b0) begin n_fail++; $display("FAIL wrap_overwritten_700_296: on_notes=%b required 0", on_notes); end
        x = 482; y = 296; #1;
        n_checks++;
        if (on_notes !== 1'b1) begin n_fail++; $display("FAIL wrap_newest_482_296: on_notes=%b required 1", on_notes); end
        for (int j = 0; j < 40; j++) begin
            int px, py;
            pick_pixel(px, py);
            x = px[10:0]; y = py[9:0]; #1;
            n_checks++;
            if (on_notes !== m_on_notes(px, py) || on !== (m_on_notes(px, py) | m_on_staff(px, py))) begin
                n_fail++;
                $display("FAIL wrap_scan(%0d,%0d): on=%b on_notes=%b required on_notes=%b", px, py, on, on_notes, m_on_notes(px, py));
            end
        end
    endtask

    task automatic test_simultaneous;
        cycle(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        repeat ($urandom_range(3, 20)) cycle(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 34, 127, 1'b1);
        // Stamped with the old tick, so one tick old now: bar starts at 792
        x = 795; y = 240; #1;
        n_checks++;
        if (on_notes !== 1'b1) begin n_fail++; $display("FAIL sim_795_240: on_notes=%b required 1", on_notes); end
        x = 791; y = 240; #1;
        n_checks++;
        if (on_notes !== 1'b0) begin n_fail++; $display("FAIL sim_791_240: on_notes=%b required 0", on_notes); end
        repeat (126) cycle(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
        x = 0; y = 240; #1;
        n_checks++;
        if (on_notes !== 1'b1) begin n_fail++; $display("FAIL age127_0_240: on_notes=%b required 1", on_notes); end
        x = 799; y = 240; #1;
        n_checks++;
        if (on_notes !== 1'b1) begin n_fail++; $display("FAIL age127_799_240: on_notes=%b required 1", on_notes); end
        cycle(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
        for (int j = 0; j < 40; j++) begin
            int px, py;
            px = int'($urandom_range(0, 799)); py = int'($urandom_range(230, 250));
            x = px[10:0]; y = py[9:0]; #1;
            n_checks++;
            if (on_notes !== 1'b0) begin
                n_fail++;
                $display("FAIL expired_scan(%0d,%0d): on_notes=%b required 0", px, py, on_notes);
            end
        end
        cycle(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
        x = 795; y = 240; #1;
        n_checks++;
        if (on_notes !== 1'b0) begin n_fail++; $display("FAIL no_alias_795_240: on_notes=%b required 0", on_notes); end
    endtask

    task automatic test_random;
        cycle(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        for (int c = 0; c < 700; c++) begin
            bit r, p, nn, nb;
            int nt, d;
            r  = ($urandom_range(0, 299) != 0);
            p  = ($urandom_range(0, 4) != 0);
            nn = ($urandom_range(0, 2) == 0);
            nb = ($urandom_range(0, 1) == 0);
            nt = int'($urandom_range(0, 63));
            d  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 127));
            cycle(r, p, nn, nt, d, nb);
            if (c % 10 == 9) begin
                for (int j = 0; j < 6; j++) begin
                    int px, py;
                    pick_pixel(px, py);
                    x = px[10:0]; y = py[9:0]; #1;
                    n_checks++;
                    if (on_notes !== m_on_notes(px, py) || on_staff !== m_on_staff(px, py) ||
                        on !== (m_on_notes(px, py) | m_on_staff(px, py))) begin
                        n_fail++;
                        $display("FAIL random_scan(%0d,%0d): on=%b on_notes=%b on_staff=%b required notes=%b staff=%b",
                                 px, py, on, on_notes, on_staff, m_on_notes(px, py), m_on_staff(px, py));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_bar();
        test_freeze();
        test_wrap();
        test_simultaneous();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_score_view
`default_nettype wire

// File: doc/score_view.md
# score_view

Scrolling music-score renderer. Records incoming note events into a fixed-capacity circular store timestamped by a tick counter. For any queried screen pixel, it answers combinationally whether that pixel belongs to a note bar or to the static staff grid. It sits between the note/tempo sources and the LCD pixel driver: the driver scans x/y and paints `on`.

## Interface
Parameters:
- SCREEN_WIDTH, 800, visible pixels per row
- SCREEN_HEIGHT, 480, visible rows
- SCREEN_WIDTH_BITS, 11, width of x
- SCREEN_HEIGHT_BITS, 10, width of y
- DISPLAYED_BEATS, 6, beats shown across the window
- SIMULTANEOUS_NOTES, 4; store capacity is CAP = 2*DISPLAYED_BEATS*SIMULTANEOUS_NOTES (48)
- BEAT_DURATION, 16, ticks per beat
- BEAT_BITS, 7, tick counter, start and duration width
- NOTE_BITS, 6, note (staff position) width
- NOTES_POS_BITS, 6, write-pointer width (must hold CAP-1)
- STEP_PX, 8, vertical pixels per staff step
- MID_NOTE, 34, note value drawn on the middle staff line

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- play  in  1  enables recording and tick advance
- new_note  in  1  one-cycle pulse: record note/duration
- note  in  NOTE_BITS  staff position of the new note
- duration  in  BEAT_BITS  length in ticks; 0 means nothing is recorded
- new_beat  in  1  one-cycle pulse: advance tick counter
- x  in  SCREEN_WIDTH_BITS  queried column
- y  in  SCREEN_HEIGHT_BITS  queried row
- on_notes  out  1  pixel lies inside a visible note bar
- on_staff  out  1  pixel lies on the staff grid
- on  out  1  on_notes | on_staff

## Operation
- Entry format: {valid, note, start, duration}, with widths 1 / NOTE_BITS / BEAT_BITS / BEAT_BITS.
- Recording: new_note with play=1 and duration≠0 writes {1, note, cur, duration} at wptr. wptr then increments and wraps CAP-1→0, overwriting the oldest entry.
- Tick: new_beat with play=1 sets cur ← cur+1, mod 2^BEAT_BITS.
- Ageing: in the same cycle as a tick, any valid entry whose age (cur − start mod 2^BEAT_BITS) equals 2^BEAT_BITS−1 before the increment is cleared, so age never aliases.
- Simultaneous new_note and new_beat: the note is stamped with the pre-increment cur, then cur increments.
- play=0: both pulses are ignored; the store and cur are frozen; the display still reflects the store.
- Note pixels:
  - TICK_PX = SCREEN_WIDTH / (DISPLAYED_BEATS*BEAT_DURATION), floored (8).
  - Per valid entry: age = cur − start (mod); sx = SCREEN_WIDTH − age*TICK_PX; ex = sx + duration*TICK_PX; yc = SCREEN_HEIGHT/2 + (MID_NOTE − note)*STEP_PX.
  - All arithmetic is signed, wide enough for no overflow.
  - Hit when sx ≤ x < ex and yc−3 ≤ y ≤ yc+3. on_notes is the OR over all CAP entries.
  - Playhead is the right edge; bars grow in from the right and scroll left. Parts off-screen are not drawn.
- Staff pixels:
  - Five 1-px horizontal lines at y = SCREEN_HEIGHT/2 + k*2*STEP_PX for k ∈ {−2..2} (208, 224, 240, 256, 272), spanning every x.
  - Vertical grid lines at x = SCREEN_WIDTH − k*BEAT_DURATION*TICK_PX for k = 1..DISPLAYED_BEATS (672, 544, …, 32), drawn only for y ∈ [208, 272].

## Timing
- Store, wptr and cur update on the clock edge after the pulse. The new state is visible on outputs in the following cycle.
- on, on_notes and on_staff are purely combinational in x, y and current state: zero latency, no pixel pipeline.
- Reset (rst=0 at an edge): cur=0, wptr=0, all valid=0.
- Reset overrides any pulse arriving in the same cycle, including mid-stream.
- After reset, on equals on_staff and on_notes=0.

## Structure
- Shared package: entry field widths and offsets, CAP, TICK_PX, staff y constants, entry struct/typedef.
- One sub-module, note_store: circular store, wptr, tick counter and ageing. It exports the CAP entries flat.
- The top does the combinational note-hit OR tree and staff decode inline.

## Test plan
- Reset, no notes: (400,240) → on=1, on_staff=1, on_notes=0; (400,241) → on=0; (672,230) → on_staff=1; (672,300) → on=0.
- Record note 34, duration 16 at cur=0, then 16 new_beat pulses: (700,240) → on_notes=1; (671,240) → 0; (700,244) → 0; (700,243) → 1.
- Two more ticks: the bar shifts left 16 px; (656,240) → on_notes=1 and (799,240) → 0.
- play=0 with new_note and new_beat pulses: store and cur unchanged, every pixel result unchanged.
- Record 49 notes (note 27+i mod 16) without ticks: the first entry is overwritten by the 49th, and wptr reads 1.
- Simultaneous new_note+new_beat: start = old cur. After 127 further ticks the entry is invalid and on_notes=0 everywhere.
